// File: rtl/e203_exu_flush_arb_pkg.sv
// Shared encodings for the EXU flush arbiter and other commit-side arbiters.
// Optional perf counters in the top are enabled by E203_FLUSH_ARB_PERF_EN.
package e203_flush_pkg;

  typedef logic [1:0] flush_src_t;

  localparam flush_src_t FLUSH_SRC_EXCP = 2'd0;
  localparam flush_src_t FLUSH_SRC_BRCH = 2'd1;
  localparam flush_src_t FLUSH_SRC_DBG  = 2'd2;

  localparam logic [1:0] FARB_IDLE = 2'd0;
  localparam logic [1:0] FARB_PEND = 2'd1;
  localparam logic [1:0] FARB_HOLD = 2'd2;

  localparam int HOLD_CNT_W = 4;

  // Index 0 has the highest priority; an empty request vector maps to index 0.
  function automatic flush_src_t prio3_idx(input logic [2:0] req);
    if (req[0])      return FLUSH_SRC_EXCP;
    else if (req[1]) return FLUSH_SRC_BRCH;
    else if (req[2]) return FLUSH_SRC_DBG;
    else             return FLUSH_SRC_EXCP;
  endfunction

endpackage

// File: rtl/e203_exu_flush_arb_if.sv
// Flush request/ack bundle between the commit-side flush sources, the arbiter and the IFU.
// master = arbiter side, slave = requester/IFU side.
interface e203_exu_flush_arb_if #(
  parameter int PC_SIZE = 32
);
  logic               excp_req, brch_req, dbg_req;
  logic               excp_ack, brch_ack, dbg_ack;
  logic [PC_SIZE-1:0] excp_op1, excp_op2, excp_pc;
  logic [PC_SIZE-1:0] brch_op1, brch_op2, brch_pc;
  logic [PC_SIZE-1:0] dbg_op1, dbg_op2, dbg_pc;

  logic               pipe_flush_req;
  logic               pipe_flush_ack;
  logic [PC_SIZE-1:0] pipe_flush_add_op1;
  logic [PC_SIZE-1:0] pipe_flush_add_op2;
  logic [PC_SIZE-1:0] pipe_flush_pc;
  logic [1:0]         pipe_flush_src;
  logic               flush_pulse;
  logic               arb_busy;

  modport master (
    input  excp_req, brch_req, dbg_req,
    input  excp_op1, excp_op2, excp_pc,
    input  brch_op1, brch_op2, brch_pc,
    input  dbg_op1, dbg_op2, dbg_pc,
    input  pipe_flush_ack,
    output excp_ack, brch_ack, dbg_ack,
    output pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2, pipe_flush_pc,
    output pipe_flush_src, flush_pulse, arb_busy
  );

  modport slave (
    output excp_req, brch_req, dbg_req,
    output excp_op1, excp_op2, excp_pc,
    output brch_op1, brch_op2, brch_pc,
    output dbg_op1, dbg_op2, dbg_pc,
    output pipe_flush_ack,
    input  excp_ack, brch_ack, dbg_ack,
    input  pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2, pipe_flush_pc,
    input  pipe_flush_src, flush_pulse, arb_busy
  );

endinterface

// File: rtl/e203_exu_flush_arb_prio3.sv
// Combinational fixed-priority picker over three requests (bit 0 highest).
// Produces a onehot0 grant and the 2-bit index of the winner.
module e203_flush_prio3
  import e203_flush_pkg::*;
(
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic [1:0] idx
);

  always_comb begin
    idx = prio3_idx(req);
    gnt = '0;
    if (|req) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/e203_exu_flush_arb.sv
// Registered arbiter/sequencer for the single EXU->IFU flush port with a post-flush holdoff.
// Define E203_FLUSH_ARB_PERF_EN to add saturating per-source flush counters.
module e203_exu_flush_arb
  import e203_flush_pkg::*;
#(
  parameter int PC_SIZE = 32,
  parameter int HOLDOFF = 1
`ifdef E203_FLUSH_ARB_PERF_EN
  ,
  parameter int CNT_W   = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  e203_exu_flush_arb_if.master  bus
`ifdef E203_FLUSH_ARB_PERF_EN
  ,
  input  logic                  perf_clr,
  output logic [CNT_W-1:0]      cnt_excp,
  output logic [CNT_W-1:0]      cnt_brch,
  output logic [CNT_W-1:0]      cnt_dbg
`endif
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_INIT = HOLD_CNT_W'(HOLDOFF);

  logic [1:0]            state_q;
  logic [HOLD_CNT_W-1:0] hold_cnt_q;
  logic [PC_SIZE-1:0]    op1_q, op2_q, pc_q;
  flush_src_t            src_q;

  logic [2:0]            req_vec;
  logic [2:0]            gnt;
  logic [1:0]            win_idx;
  logic                  capture;
  logic                  accept;
  logic [PC_SIZE-1:0]    sel_op1, sel_op2, sel_pc;

  assign req_vec = {bus.dbg_req, bus.brch_req, bus.excp_req};

  e203_flush_prio3 u_prio (
    .req (req_vec),
    .gnt (gnt),
    .idx (win_idx)
  );

  // Acks are gated by reset so a held request is only acked once it can really be captured.
  assign capture = (state_q == FARB_IDLE) & (|req_vec) & ~rst;
  assign accept  = (state_q == FARB_PEND) & bus.pipe_flush_ack;

  assign bus.excp_ack = capture & gnt[0];
  assign bus.brch_ack = capture & gnt[1];
  assign bus.dbg_ack  = capture & gnt[2];

  always_comb begin
    sel_op1 = bus.excp_op1;
    sel_op2 = bus.excp_op2;
    sel_pc  = bus.excp_pc;
    case (win_idx)
      FLUSH_SRC_BRCH: begin
        sel_op1 = bus.brch_op1;
        sel_op2 = bus.brch_op2;
        sel_pc  = bus.brch_pc;
      end
      FLUSH_SRC_DBG: begin
        sel_op1 = bus.dbg_op1;
        sel_op2 = bus.dbg_op2;
        sel_pc  = bus.dbg_pc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FARB_IDLE;
      hold_cnt_q <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      pc_q       <= '0;
      src_q      <= FLUSH_SRC_EXCP;
    end else begin
      case (state_q)
        FARB_IDLE: begin
          if (capture) begin
            state_q <= FARB_PEND;
            op1_q   <= sel_op1;
            op2_q   <= sel_op2;
            pc_q    <= sel_pc;
            src_q   <= win_idx;
          end
        end
        FARB_PEND: begin
          if (accept) begin
            if (HOLDOFF == 0) begin
              state_q <= FARB_IDLE;
            end else begin
              state_q    <= FARB_HOLD;
              hold_cnt_q <= HOLD_INIT;
            end
          end
        end
        FARB_HOLD: begin
          hold_cnt_q <= hold_cnt_q - 1'b1;
          if (hold_cnt_q <= HOLD_CNT_W'(1)) state_q <= FARB_IDLE;
        end
        default: state_q <= FARB_IDLE;
      endcase
    end
  end

  assign bus.pipe_flush_req     = (state_q == FARB_PEND);
  assign bus.pipe_flush_add_op1 = op1_q;
  assign bus.pipe_flush_add_op2 = op2_q;
  assign bus.pipe_flush_pc      = pc_q;
  assign bus.pipe_flush_src     = src_q;
  assign bus.flush_pulse        = accept;
  assign bus.arb_busy           = (state_q != FARB_IDLE);

`ifdef E203_FLUSH_ARB_PERF_EN
  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      cnt_excp <= '0;
      cnt_brch <= '0;
      cnt_dbg  <= '0;
    end else if (accept) begin
      case (src_q)
        FLUSH_SRC_EXCP: if (~&cnt_excp) cnt_excp <= cnt_excp + CNT_W'(1);
        FLUSH_SRC_BRCH: if (~&cnt_brch) cnt_brch <= cnt_brch + CNT_W'(1);
        FLUSH_SRC_DBG:  if (~&cnt_dbg)  cnt_dbg  <= cnt_dbg + CNT_W'(1);
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_e203_exu_flush_arb.sv
// Directed self-checking bench for e203_exu_flush_arb: HOLDOFF=1 and HOLDOFF=0 instances,
// scoreboard of expected flush payloads; perf checks compile in with E203_FLUSH_ARB_PERF_EN.
module tb_e203_exu_flush_arb;
  import e203_flush_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  e203_exu_flush_arb_if #(.PC_SIZE(32)) b0 ();
  e203_exu_flush_arb_if #(.PC_SIZE(32)) b1 ();

`ifdef E203_FLUSH_ARB_PERF_EN
  logic       perf_clr0, perf_clr1;
  logic [1:0] cnt_excp0, cnt_brch0, cnt_dbg0;
  logic [1:0] cnt_excp1, cnt_brch1, cnt_dbg1;
`endif

  e203_exu_flush_arb #(
    .PC_SIZE (32),
    .HOLDOFF (1)
`ifdef E203_FLUSH_ARB_PERF_EN
    ,
    .CNT_W   (2)
`endif
  ) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
`ifdef E203_FLUSH_ARB_PERF_EN
    ,
    .perf_clr (perf_clr0),
    .cnt_excp (cnt_excp0),
    .cnt_brch (cnt_brch0),
    .cnt_dbg  (cnt_dbg0)
`endif
  );

  e203_exu_flush_arb #(
    .PC_SIZE (32),
    .HOLDOFF (0)
`ifdef E203_FLUSH_ARB_PERF_EN
    ,
    .CNT_W   (2)
`endif
  ) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
`ifdef E203_FLUSH_ARB_PERF_EN
    ,
    .perf_clr (perf_clr1),
    .cnt_excp (cnt_excp1),
    .cnt_brch (cnt_brch1),
    .cnt_dbg  (cnt_dbg1)
`endif
  );

  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] pc;
  } flush_t;

  flush_t sb_q[$];
  int n_cmp   = 0;
  int n_bad   = 0;
  int cycle_no = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cycle_no++;
  endtask

  function automatic logic [2:0] acks0();
    return {b0.dbg_ack, b0.brch_ack, b0.excp_ack};
  endfunction

  // Raise a request on the HOLDOFF=1 instance and record the flush it should produce.
  task automatic applyStimulus(input int s, input logic [31:0] op1, input logic [31:0] op2,
                               input logic [31:0] pc);
    flush_t e;
    case (s)
      0: begin b0.excp_req = 1'b1; b0.excp_op1 = op1; b0.excp_op2 = op2; b0.excp_pc = pc; end
      1: begin b0.brch_req = 1'b1; b0.brch_op1 = op1; b0.brch_op2 = op2; b0.brch_pc = pc; end
      default: begin b0.dbg_req = 1'b1; b0.dbg_op1 = op1; b0.dbg_op2 = op2; b0.dbg_pc = pc; end
    endcase
    e.src = 2'(s);
    e.op1 = op1;
    e.op2 = op2;
    e.pc  = pc;
    sb_q.push_back(e);
  endtask

  task automatic dropReq(input int s);
    case (s)
      0: b0.excp_req = 1'b0;
      1: b0.brch_req = 1'b0;
      default: b0.dbg_req = 1'b0;
    endcase
  endtask

  task automatic waitReq(input int budget);
    for (int i = 0; i < budget && !b0.pipe_flush_req; i++) cyc();
    checkOutput("wait_req", 64'(b0.pipe_flush_req), 64'd1);
  endtask

  task automatic waitAck(input int s, input int budget, output int at_cycle);
    logic [2:0] e;
    e = 3'b001 << s;
    #1;
    for (int i = 0; i < budget && acks0() == 3'b000; i++) cyc();
    at_cycle = cycle_no;
    checkOutput("ack_onehot", 64'(acks0()), 64'(e));
  endtask

  // IFU side: accept the presented flush and compare it with the oldest expected one.
  task automatic ifuAccept(input bit clr);
    flush_t e;
    waitReq(20);
    b0.pipe_flush_ack = 1'b1;
`ifdef E203_FLUSH_ARB_PERF_EN
    perf_clr0 = clr;
`endif
    #1;
    checkOutput("flush_pulse", 64'(b0.flush_pulse), 64'd1);
    checkOutput("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checkOutput("flush_src", 64'(b0.pipe_flush_src), 64'(e.src));
      checkOutput("flush_op1", 64'(b0.pipe_flush_add_op1), 64'(e.op1));
      checkOutput("flush_op2", 64'(b0.pipe_flush_add_op2), 64'(e.op2));
      checkOutput("flush_pc", 64'(b0.pipe_flush_pc), 64'(e.pc));
    end
    cyc();
    b0.pipe_flush_ack = 1'b0;
`ifdef E203_FLUSH_ARB_PERF_EN
    perf_clr0 = 1'b0;
`endif
    if (clr) begin end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t, t_prev;
    rst = 1'b1;
    {b0.excp_req, b0.brch_req, b0.dbg_req, b0.pipe_flush_ack} = '0;
    {b0.excp_op1, b0.excp_op2, b0.excp_pc} = '0;
    {b0.brch_op1, b0.brch_op2, b0.brch_pc} = '0;
    {b0.dbg_op1, b0.dbg_op2, b0.dbg_pc} = '0;
    {b1.excp_req, b1.brch_req, b1.dbg_req, b1.pipe_flush_ack} = '0;
    {b1.excp_op1, b1.excp_op2, b1.excp_pc} = '0;
    {b1.brch_op1, b1.brch_op2, b1.brch_pc} = '0;
    {b1.dbg_op1, b1.dbg_op2, b1.dbg_pc} = '0;
`ifdef E203_FLUSH_ARB_PERF_EN
    perf_clr0 = 1'b0;
    perf_clr1 = 1'b0;
`endif
    cyc();
    cyc();

    // Reset state; a request while rst is high must not be acked.
    b0.brch_req = 1'b1;
    #1;
    checkOutput("rst_req", 64'(b0.pipe_flush_req), 64'd0);
    checkOutput("rst_busy", 64'(b0.arb_busy), 64'd0);
    checkOutput("rst_src", 64'(b0.pipe_flush_src), 64'd0);
    checkOutput("rst_op1", 64'(b0.pipe_flush_add_op1), 64'd0);
    checkOutput("rst_pulse", 64'(b0.flush_pulse), 64'd0);
    checkOutput("rst_acks", 64'(acks0()), 64'd0);
    b0.brch_req = 1'b0;
    rst = 1'b0;
    cyc();

    // Single branch flush, then back-to-back recapture after the holdoff.
    applyStimulus(1, 32'h8000_0000, 32'h0000_0010, 32'h8000_0010);
    #1;
    checkOutput("t1_ack", 64'(acks0()), 64'b010);
    checkOutput("t1_req_lo", 64'(b0.pipe_flush_req), 64'd0);
    cyc();
    dropReq(1);
    #1;
    checkOutput("t1_req_hi", 64'(b0.pipe_flush_req), 64'd1);
    checkOutput("t1_busy", 64'(b0.arb_busy), 64'd1);
    checkOutput("t1_src", 64'(b0.pipe_flush_src), 64'd1);
    checkOutput("t1_no_ack", 64'(acks0()), 64'd0);
    cyc();
    cyc();
    checkOutput("t1_op1_stable", 64'(b0.pipe_flush_add_op1), 64'h8000_0000);
    ifuAccept(1'b0);
    applyStimulus(1, 32'h0000_1000, 32'h0000_0004, 32'h0000_1004);
    #1;
    checkOutput("t1_hold_noack", 64'(acks0()), 64'd0);
    checkOutput("t1_hold_req", 64'(b0.pipe_flush_req), 64'd0);
    checkOutput("t1_hold_busy", 64'(b0.arb_busy), 64'd1);
    cyc();
    checkOutput("t1_recapture", 64'(acks0()), 64'b010);
    cyc();
    dropReq(1);
    ifuAccept(1'b0);
    cyc();

    // All three together: served excp, brch, dbg, spaced by 1 + HOLDOFF + 1 cycles.
    applyStimulus(0, 32'hA000_0000, 32'h0000_0100, 32'hA000_0100);
    applyStimulus(1, 32'hB000_0000, 32'h0000_0200, 32'hB000_0200);
    applyStimulus(2, 32'hC000_0000, 32'h0000_0300, 32'hC000_0300);
    t_prev = 0;
    for (int k = 0; k < 3; k++) begin
      waitAck(k, 10, t);
      if (k > 0) checkOutput("t2_spacing", 64'(t - t_prev), 64'd3);
      t_prev = t;
      cyc();
      dropReq(k);
      ifuAccept(1'b0);
    end
    cyc();

    // No preemption of a pending branch flush by a later exception.
    applyStimulus(1, 32'h1234_5678, 32'h0000_0008, 32'h1234_5680);
    #1;
    checkOutput("t3_brch_ack", 64'(acks0()), 64'b010);
    cyc();
    dropReq(1);
    applyStimulus(0, 32'h0000_0180, 32'h0000_0000, 32'h0000_0180);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("t3_no_preempt", 64'(acks0()), 64'd0);
      checkOutput("t3_src_stable", 64'(b0.pipe_flush_src), 64'd1);
      checkOutput("t3_op1_stable", 64'(b0.pipe_flush_add_op1), 64'h1234_5678);
      cyc();
    end
    ifuAccept(1'b0);
    #1;
    checkOutput("t3_hold_noack", 64'(acks0()), 64'd0);
    cyc();
    checkOutput("t3_excp_ack", 64'(acks0()), 64'b001);
    cyc();
    dropReq(0);
    ifuAccept(1'b0);
    cyc();

    // HOLDOFF = 0 with request and IFU ack held: req alternates 0/1.
    b1.brch_req = 1'b1;
    b1.brch_op1 = 32'h0000_2000;
    b1.brch_op2 = 32'h0000_0020;
    b1.brch_pc  = 32'h0000_2020;
    b1.pipe_flush_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checkOutput("t4_req", 64'(b1.pipe_flush_req), 64'(i % 2));
      checkOutput("t4_ack", 64'(b1.brch_ack), 64'((i + 1) % 2));
      if (i % 2 == 1) begin
        checkOutput("t4_pulse", 64'(b1.flush_pulse), 64'd1);
        checkOutput("t4_src", 64'(b1.pipe_flush_src), 64'd1);
        checkOutput("t4_op1", 64'(b1.pipe_flush_add_op1), 64'h0000_2000);
      end
      cyc();
    end
    b1.brch_req = 1'b0;
    b1.pipe_flush_ack = 1'b0;

    // Reset while pending drops the flush; a held dbg request is captured right after.
    b0.brch_req = 1'b1;
    b0.brch_op1 = 32'hDEAD_0000;
    #1;
    checkOutput("t5_brch_ack", 64'(acks0()), 64'b010);
    cyc();
    b0.brch_req = 1'b0;
    applyStimulus(2, 32'h0000_0800, 32'h0000_0000, 32'h0000_0800);
    rst = 1'b1;
    #1;
    checkOutput("t5_pend", 64'(b0.pipe_flush_req), 64'd1);
    checkOutput("t5_rst_noack", 64'(acks0()), 64'd0);
    cyc();
    rst = 1'b0;
    #1;
    checkOutput("t5_req_clr", 64'(b0.pipe_flush_req), 64'd0);
    checkOutput("t5_busy_clr", 64'(b0.arb_busy), 64'd0);
    checkOutput("t5_op1_clr", 64'(b0.pipe_flush_add_op1), 64'd0);
    checkOutput("t5_dbg_ack", 64'(acks0()), 64'b100);
    cyc();
    dropReq(2);
    ifuAccept(1'b0);
    cyc();

`ifdef E203_FLUSH_ARB_PERF_EN
    // Saturating 2-bit brch counter, then clear coincident with a flush.
    perf_clr0 = 1'b1;
    cyc();
    perf_clr0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 32'h0000_4000 + 32'(k), 32'h0000_0004, 32'h0000_4004);
      waitAck(1, 10, t);
      cyc();
      dropReq(1);
      ifuAccept(1'b0);
      checkOutput("perf_brch_cnt", 64'(cnt_brch0), 64'((k + 1 > 3) ? 3 : k + 1));
    end
    checkOutput("perf_excp_cnt", 64'(cnt_excp0), 64'd0);
    applyStimulus(1, 32'h0000_5000, 32'h0000_0004, 32'h0000_5004);
    waitAck(1, 10, t);
    cyc();
    dropReq(1);
    ifuAccept(1'b1);
    checkOutput("perf_clr_wins", 64'(cnt_brch0), 64'd0);
    cyc();
`endif

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
